// File: rtl/axi_bridge.sv
// axi_bridge: cache-to-AXI4 master bridge with independent read/write FSMs; sticky err_o only when AXI_BRIDGE_ERR_EN is defined
module axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_valid_i,
    input  logic [31:0] rd_addr_i,
    input  logic [7:0]  rd_len_i,
    output logic        rd_ready_o,
    output logic        rd_last_o,
    output logic [63:0] rd_data_o,
    input  logic        wr_valid_i,
    input  logic [31:0] wr_addr_i,
    input  logic [7:0]  wr_len_i,
    input  logic [2:0]  wr_size_i,
    input  logic [7:0]  wr_strb_i,
    input  logic [63:0] wr_data_i,
    output logic        wr_ready_o,
    output logic        wr_last_o,
    output logic        arvalid,
    input  logic        arready,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        rvalid,
    output logic        rready,
    input  logic [63:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        wvalid,
    input  logic        wready,
    output logic [63:0] wdata,
    output logic [7:0]  wstrb,
    output logic        wlast,
    input  logic        bvalid,
    output logic        bready,
    input  logic [1:0]  bresp,
    output logic        err_o
);
    localparam logic [1:0] R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2;
    localparam logic [1:0] W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3;
    logic [1:0]  r_rstate, r_wstate;
    logic [7:0]  r_cnt;
    logic        w_rhs, w_whs, w_bhs;
    assign arid    = AXI_ID;
    assign awid    = AXI_ID;
    assign arsize  = 3'd3;
    assign arburst = 2'b01;
    assign awburst = 2'b01;
    assign rready  = r_rstate == R_DATA;
    assign wvalid  = r_wstate == W_DATA;
    assign bready  = r_wstate == W_RESP;
    assign wdata   = wvalid ? wr_data_i : 64'd0;
    assign wstrb   = wvalid ? wr_strb_i : 8'd0;
    assign wlast   = wvalid && r_cnt == awlen;
    assign wr_ready_o = wvalid & wready;
    assign w_rhs   = rvalid & rready;
    assign w_whs   = wvalid & wready;
    assign w_bhs   = bvalid & bready;
    // The last-pulse cycle blocks re-acceptance since the cache still holds valid then
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate   <= R_IDLE;
            arvalid    <= 1'b0;
            araddr     <= 32'd0;
            arlen      <= 8'd0;
            rd_ready_o <= 1'b0;
            rd_last_o  <= 1'b0;
            rd_data_o  <= 64'd0;
        end else begin
            rd_ready_o <= w_rhs;
            rd_last_o  <= w_rhs & rlast;
            if (w_rhs) rd_data_o <= rdata;
            case (r_rstate)
                R_IDLE: if (rd_valid_i && !rd_last_o) begin
                    r_rstate <= R_ADDR;
                    arvalid  <= 1'b1;
                    araddr   <= rd_addr_i;
                    arlen    <= rd_len_i;
                end
                R_ADDR: if (arready) begin
                    r_rstate <= R_DATA;
                    arvalid  <= 1'b0;
                end
                R_DATA: if (w_rhs && rlast) r_rstate <= R_IDLE;
                default: r_rstate <= R_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate  <= W_IDLE;
            r_cnt     <= 8'd0;
            awvalid   <= 1'b0;
            awaddr    <= 32'd0;
            awlen     <= 8'd0;
            awsize    <= 3'd0;
            wr_last_o <= 1'b0;
        end else begin
            wr_last_o <= 1'b0;
            case (r_wstate)
                W_IDLE: if (wr_valid_i && !wr_last_o) begin
                    r_wstate <= W_ADDR;
                    awvalid  <= 1'b1;
                    awaddr   <= wr_addr_i;
                    awlen    <= wr_len_i;
                    awsize   <= wr_size_i;
                    r_cnt    <= 8'd0;
                end
                W_ADDR: if (awready) begin
                    r_wstate <= W_DATA;
                    awvalid  <= 1'b0;
                end
                W_DATA: if (w_whs) begin
                    r_cnt <= r_cnt + 8'd1;
                    if (wlast) r_wstate <= W_RESP;
                end
                default: if (bvalid) begin
                    r_wstate  <= W_IDLE;
                    wr_last_o <= 1'b1;
                end
            endcase
        end
    end
`ifdef AXI_BRIDGE_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) err_o <= 1'b0;
        else if ((w_rhs && rresp != 2'b00) || (w_bhs && bresp != 2'b00)) err_o <= 1'b1;
    end
`else
    logic w_unused;
    assign w_unused = ^{rresp, bresp, w_bhs};
    assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_axi_bridge.sv
// tb_axi_bridge: directed self-checking bench for axi_bridge
module tb_axi_bridge;
    logic clk = 0, rst = 1;
    logic rd_valid_i = 0, wr_valid_i = 0;
    logic [31:0] rd_addr_i = 0, wr_addr_i = 0;
    logic [7:0] rd_len_i = 0, wr_len_i = 0, wr_strb_i = 0;
    logic [2:0] wr_size_i = 0;
    logic [63:0] wr_data_i = 0, rdata = 0;
    logic rd_ready_o, rd_last_o, wr_ready_o, wr_last_o, err_o;
    logic [63:0] rd_data_o, wdata;
    logic arvalid, awvalid, wvalid, rready, bready, wlast;
    logic arready = 0, awready = 0, wready = 0, rvalid = 0, rlast = 0, bvalid = 0;
    logic [3:0] arid, awid;
    logic [31:0] araddr, awaddr;
    logic [7:0] arlen, awlen, wstrb;
    logic [2:0] arsize, awsize;
    logic [1:0] arburst, awburst, rresp = 0, bresp = 0;
    int checks = 0, errors = 0;
    logic err_exp;

    axi_bridge dut (
        .clk(clk), .rst(rst),
        .rd_valid_i(rd_valid_i), .rd_addr_i(rd_addr_i), .rd_len_i(rd_len_i),
        .rd_ready_o(rd_ready_o), .rd_last_o(rd_last_o), .rd_data_o(rd_data_o),
        .wr_valid_i(wr_valid_i), .wr_addr_i(wr_addr_i), .wr_len_i(wr_len_i),
        .wr_size_i(wr_size_i), .wr_strb_i(wr_strb_i), .wr_data_i(wr_data_i),
        .wr_ready_o(wr_ready_o), .wr_last_o(wr_last_o),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef AXI_BRIDGE_ERR_EN
        err_exp = 1'b1;
`else
        err_exp = 1'b0;
`endif
        tick(); tick();
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_bready", bready, 0);
        chk("rst_rd_ready", rd_ready_o, 0);
        chk("rst_rd_last", rd_last_o, 0);
        chk("rst_rd_data", rd_data_o, 0);
        chk("rst_wr_last", wr_last_o, 0);
        chk("rst_err", err_o, 0);
        rst = 0;
        tick();
        // read burst of two beats with 3-cycle arready stall
        rd_valid_i = 1; rd_addr_i = 32'h8000_0010; rd_len_i = 8'd1;
        tick();
        chk("r_arvalid", arvalid, 1);
        chk("r_araddr", araddr, 64'h8000_0010);
        chk("r_arlen", arlen, 1);
        chk("r_arsize", arsize, 3);
        chk("r_arburst", arburst, 1);
        chk("r_arid", arid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("r_arvalid_stall", arvalid, 1);
        end
        arready = 1;
        tick();
        arready = 0;
        chk("r_arvalid_clr", arvalid, 0);
        chk("r_rready", rready, 1);
        rvalid = 1; rdata = 64'h1111_1111_1111_1111; rlast = 0;
        tick();
        chk("r_b1_ready", rd_ready_o, 1);
        chk("r_b1_last", rd_last_o, 0);
        chk("r_b1_data", rd_data_o, 64'h1111_1111_1111_1111);
        rdata = 64'h2222_2222_2222_2222; rlast = 1;
        tick();
        chk("r_b2_ready", rd_ready_o, 1);
        chk("r_b2_last", rd_last_o, 1);
        chk("r_b2_data", rd_data_o, 64'h2222_2222_2222_2222);
        chk("r_rready_idle", rready, 0);
        tick();
        rd_valid_i = 0; rvalid = 0; rlast = 0;
        chk("r_no_reissue", arvalid, 0);
        chk("r_ready_drop", rd_ready_o, 0);
        // two-beat write with wready low for 2 cycles, error response
        wr_valid_i = 1; wr_addr_i = 32'h8000_0100; wr_len_i = 1; wr_size_i = 3;
        wr_strb_i = 8'hFF; wr_data_i = 64'hAAAA_0000_0000_0001;
        tick();
        chk("w_awvalid", awvalid, 1);
        chk("w_awaddr", awaddr, 64'h8000_0100);
        chk("w_awlen", awlen, 1);
        chk("w_awburst", awburst, 1);
        awready = 1;
        tick();
        awready = 0;
        chk("w_awvalid_clr", awvalid, 0);
        chk("w_wvalid", wvalid, 1);
        chk("w_wdata1", wdata, 64'hAAAA_0000_0000_0001);
        chk("w_wlast1", wlast, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("w_wvalid_stall", wvalid, 1);
            chk("w_wrready_stall", wr_ready_o, 0);
        end
        wready = 1; #1;
        chk("w_b1_wrready", wr_ready_o, 1);
        chk("w_b1_wlast", wlast, 0);
        tick();
        wr_data_i = 64'hBBBB_0000_0000_0002; #1;
        chk("w_b2_wdata", wdata, 64'hBBBB_0000_0000_0002);
        chk("w_b2_wlast", wlast, 1);
        chk("w_b2_wrready", wr_ready_o, 1);
        tick();
        wready = 0;
        chk("w_wvalid_resp", wvalid, 0);
        chk("w_bready", bready, 1);
        chk("w_wr_last_early", wr_last_o, 0);
        bvalid = 1; bresp = 2'b10;
        tick();
        bvalid = 0; bresp = 0; wr_valid_i = 0;
        chk("w_wr_last", wr_last_o, 1);
        chk("w_bready_idle", bready, 0);
        chk("w_err", err_o, err_exp);
        tick();
        chk("w_wr_last_pulse", wr_last_o, 0);
        chk("w_no_reissue", awvalid, 0);
        chk("w_err_sticky", err_o, err_exp);
        // single-beat device write
        wr_valid_i = 1; wr_addr_i = 32'h1000_0000; wr_len_i = 0; wr_size_i = 2;
        wr_strb_i = 8'h0F; wr_data_i = 64'h0000_0000_DEAD_BEEF;
        tick();
        chk("d_awsize", awsize, 2);
        chk("d_awlen", awlen, 0);
        awready = 1;
        tick();
        awready = 0; wready = 1; #1;
        chk("d_wlast", wlast, 1);
        chk("d_wstrb", wstrb, 8'h0F);
        chk("d_wrready", wr_ready_o, 1);
        tick();
        wready = 0;
        chk("d_bready", bready, 1);
        bvalid = 1;
        tick();
        bvalid = 0; wr_valid_i = 0;
        chk("d_wr_last", wr_last_o, 1);
        tick();
        // concurrent read and write, two beats each
        rd_valid_i = 1; rd_addr_i = 32'h8000_0200; rd_len_i = 1;
        wr_valid_i = 1; wr_addr_i = 32'h8000_0200; wr_len_i = 1; wr_size_i = 3;
        wr_strb_i = 8'hFF; wr_data_i = 64'h4444_4444_4444_4444;
        arready = 1; awready = 1;
        tick();
        chk("c_arvalid", arvalid, 1);
        chk("c_awvalid", awvalid, 1);
        tick();
        arready = 0; awready = 0;
        chk("c_rready", rready, 1);
        chk("c_wvalid", wvalid, 1);
        rvalid = 1; rdata = 64'h3333_3333_3333_3333; wready = 1; #1;
        chk("c_w1_wrready", wr_ready_o, 1);
        chk("c_w1_wlast", wlast, 0);
        tick();
        chk("c_r1_ready", rd_ready_o, 1);
        chk("c_r1_data", rd_data_o, 64'h3333_3333_3333_3333);
        rdata = 64'h6666_6666_6666_6666; rlast = 1; wr_data_i = 64'h5555_5555_5555_5555; #1;
        chk("c_w2_wlast", wlast, 1);
        chk("c_w2_wdata", wdata, 64'h5555_5555_5555_5555);
        tick();
        chk("c_r2_last", rd_last_o, 1);
        chk("c_r2_data", rd_data_o, 64'h6666_6666_6666_6666);
        chk("c_bready", bready, 1);
        rvalid = 0; rlast = 0; wready = 0; bvalid = 1; rd_valid_i = 0;
        tick();
        bvalid = 0; wr_valid_i = 0;
        chk("c_wr_last", wr_last_o, 1);
        chk("c_rd_ready_done", rd_ready_o, 0);
        tick();
        chk("c_wvalid_idle", wvalid, 0);
        // stray rvalid while idle is ignored
        rvalid = 1; rlast = 1; rdata = 64'h9999;
        tick();
        rvalid = 0; rlast = 0;
        chk("i_stray_rvalid", rd_ready_o, 0);
        // reset in the middle of a read burst
        rd_valid_i = 1; rd_addr_i = 32'h8000_0300; rd_len_i = 1; arready = 1;
        tick();
        tick();
        arready = 0; rvalid = 1; rdata = 64'h7777_7777_7777_7777;
        tick();
        chk("m_b1_ready", rd_ready_o, 1);
        rvalid = 0; rst = 1;
        tick();
        rst = 0; rd_valid_i = 0; err_exp = 0;
        chk("m_rready", rready, 0);
        chk("m_arvalid", arvalid, 0);
        chk("m_araddr", araddr, 0);
        chk("m_arlen", arlen, 0);
        chk("m_rd_ready", rd_ready_o, 0);
        chk("m_rd_data", rd_data_o, 0);
        chk("m_err", err_o, 0);
        rvalid = 1; rdata = 64'h1234;
        tick();
        rvalid = 0;
        chk("m_after_rready", rready, 0);
        chk("m_after_rd_ready", rd_ready_o, 0);
        rd_valid_i = 1; rd_addr_i = 32'h8000_0020; rd_len_i = 0; arready = 1;
        tick();
        chk("n_araddr", araddr, 64'h8000_0020);
        tick();
        arready = 0; rvalid = 1; rlast = 1; rdata = 64'h8888_8888_8888_8888;
        tick();
        rvalid = 0; rlast = 0; rd_valid_i = 0;
        chk("n_ready", rd_ready_o, 1);
        chk("n_last", rd_last_o, 1);
        chk("n_data", rd_data_o, 64'h8888_8888_8888_8888);
        tick();
        chk("n_idle", rready, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_bridge.md
AXI_BRIDGE -- requirements
Module: ysyx_22041412_axi_bridge

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'd0, the ID driven on arid/awid.
REQ-002 SHALL have ports clk (in, 1, sole clock) and rst (in, 1, synchronous active-high reset).
REQ-003 Cache read side SHALL have ports: rd_valid_i (in, 1, request held until rd_last_o); rd_addr_i (in, 32, start address); rd_len_i (in, 8, beats-1); rd_ready_o (out, 1, beat data valid pulse); rd_last_o (out, 1, final-beat pulse); rd_data_o (out, 64, beat data).
REQ-004 Cache write side SHALL have ports: wr_valid_i (in, 1, request held until wr_last_o); wr_addr_i (in, 32); wr_len_i (in, 8, beats-1); wr_size_i (in, 3, AXI size code); wr_strb_i (in, 8, byte mask); wr_data_i (in, 64, current beat); wr_ready_o (out, 1, beat consumed pulse); wr_last_o (out, 1, response-received pulse).
REQ-005 AXI4 master side SHALL have ports: arvalid/arready/arid[3:0]/araddr[31:0]/arlen[7:0]/arsize[2:0]/arburst[1:0]; rvalid/rready/rdata[63:0]/rresp[1:0]/rlast; awvalid/awready/awid[3:0]/awaddr[31:0]/awlen[7:0]/awsize[2:0]/awburst[1:0]; wvalid/wready/wdata[63:0]/wstrb[7:0]/wlast; bvalid/bready/bresp[1:0]; valid/ready per AXI direction.
REQ-006 SHALL have output err_o (out, 1, sticky error flag).

Function
REQ-007 Read FSM SHALL have states R_IDLE, R_ADDR, R_DATA; write FSM W_IDLE, W_ADDR, W_DATA, W_RESP; both independent and concurrent.
REQ-008 R_IDLE -> R_ADDR on rd_valid_i; araddr/arlen registered from rd_addr_i/rd_len_i; arsize=3'd3; arburst=INCR (2'b01); arvalid=1 in R_ADDR.
REQ-009 R_ADDR -> R_DATA on arvalid&arready; arvalid cleared same edge.
REQ-010 rready SHALL be 1 throughout R_DATA, 0 elsewhere.
REQ-011 On rvalid&rready: rd_data_o<=rdata, rd_ready_o<=1 next cycle (1-cycle latency); rd_last_o<=rlast in same cycle; else both 0.
REQ-012 R_DATA -> R_IDLE on rvalid&rready&rlast; new request accepted no earlier than the cycle after rd_last_o.
REQ-013 W_IDLE -> W_ADDR on wr_valid_i; awaddr/awlen/awsize registered; awburst=INCR; beat counter cleared to 0.
REQ-014 W_ADDR -> W_DATA on awvalid&awready; wdata/wstrb combinationally equal wr_data_i/wr_strb_i during W_DATA; wvalid=1 in W_DATA only.
REQ-015 wlast SHALL equal (beat counter == awlen) during W_DATA; counter is 8-bit, increments on wvalid&wready.
REQ-016 wr_ready_o SHALL be combinational wvalid&wready; cache presents next beat the following cycle.
REQ-017 W_DATA -> W_RESP on handshake with wlast=1; bready=1 only in W_RESP.
REQ-018 W_RESP -> W_IDLE on bvalid; wr_last_o pulses 1 cycle, registered.
REQ-019 AXI valids SHALL NOT drop before handshake, regardless of arready/awready/wready stall length.
REQ-020 rvalid outside R_DATA or bvalid outside W_RESP SHALL be ignored.
REQ-021 Read and write to same address concurrently: no ordering enforced; cache guarantees ordering.

Reset
REQ-022 rst SHALL force R_IDLE/W_IDLE, clear beat counter, and drive every output to 0 (arvalid, awvalid, wvalid, rready, bready, rd_ready_o, rd_last_o, rd_data_o, wr_last_o, err_o, addresses/lengths).
REQ-023 Reset mid-burst SHALL abandon the transaction immediately; no further AXI valids until a new request.

Configuration
REQ-024 With AXI_BRIDGE_ERR_EN defined: err_o sets sticky on rresp!=0 (R handshake) or bresp!=0 (B handshake), cleared only by rst.
REQ-025 Without AXI_BRIDGE_ERR_EN: err_o tied 0; rresp/bresp ignored; handshake behaviour identical.

Verification
REQ-026 Read rd_addr_i=0x80000010, rd_len_i=1, arready after 3 stall cycles, rdata 0x11..11 then 0x22..22 -> araddr=0x80000010, arlen=1, two rd_ready_o pulses, rd_last_o with second.
REQ-027 Write wr_addr_i=0x80000100, wr_len_i=1, wready low 2 cycles -> wlast only on beat 2, two wr_ready_o, wr_last_o one cycle after bvalid.
REQ-028 Device write wr_len_i=0, wr_size_i=2, wr_strb_i=0x0F -> single beat, wlast=1, awsize=2, wstrb=0x0F.
REQ-029 Concurrent read (len 1) and write (len 1) issued same cycle -> both complete, no beat lost or duplicated.
REQ-030 rst asserted mid read burst after beat 1 -> next cycle all outputs 0, FSMs idle; new read then completes normally.
REQ-031 With AXI_BRIDGE_ERR_EN, bresp=2'b10 -> err_o=1 held; without macro -> err_o stays 0.
